// File: rtl/spi_coef_loader.sv
// Byte-level command decoder with a double-buffered coefficient bank.
// Taps are loaded into shadow registers and copied to the modulator-facing set only on COMMIT.
module spi_coef_loader #(
   parameter int COEF_W = 5,
   parameter int N_TAPS = 8,
   parameter int ADDR_W = 3
) (
   input  logic                       SCLK,
   input  logic                       reset,
   input  logic                       frame_start,
   input  logic                       rx_valid,
   input  logic [7:0]                 rx_byte,
   output logic [N_TAPS*COEF_W-1:0]   coef_cos_1,
   output logic [N_TAPS*COEF_W-1:0]   coef_sin_1,
   output logic [N_TAPS*COEF_W-1:0]   coef_cos_2,
   output logic [N_TAPS*COEF_W-1:0]   coef_sin_2,
   output logic                       commit_pulse,
   output logic                       err,
   output logic [7:0]                 frame_bytes
);

   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_CMD   = 2'd1;
   localparam logic [1:0] S_DATA  = 2'd2;
   localparam logic [1:0] S_DRAIN = 2'd3;

   logic [1:0]        r_state;
   logic [1:0]        r_bank;
   logic              r_autoInc;
   logic [ADDR_W-1:0] r_addr;
   logic [COEF_W-1:0] r_shadow [4][N_TAPS];
   logic [COEF_W-1:0] r_active [4][N_TAPS];
   logic              r_commitPulse;
   logic              r_err;
   logic [7:0]        r_frameBytes;

   logic [7:0]        w_upperBits;
   logic              w_dataOk;

   // A data byte is only a legal coefficient if nothing is set above the coefficient width.
   assign w_upperBits = rx_byte >> COEF_W;
   assign w_dataOk    = (w_upperBits == 8'd0);

   always_ff @(posedge SCLK) begin
      if (reset) begin
         r_state       <= S_IDLE;
         r_bank        <= '0;
         r_autoInc     <= 1'b0;
         r_addr        <= '0;
         r_commitPulse <= 1'b0;
         r_err         <= 1'b0;
         r_frameBytes  <= '0;
         for (int b = 0; b < 4; b++) begin
            for (int k = 0; k < N_TAPS; k++) begin
               r_shadow[b][k] <= '0;
               r_active[b][k] <= '0;
            end
         end
      end else begin
         r_commitPulse <= 1'b0;
         // A new frame always wins; a byte arriving on the same edge is dropped.
         if (frame_start) begin
            r_state      <= S_CMD;
            r_frameBytes <= '0;
         end else if (rx_valid) begin
            case (r_state)
               S_CMD: begin
                  r_state <= S_DRAIN;
                  case (rx_byte[7:6])
                     2'b00: begin
                        r_bank    <= rx_byte[5:4];
                        r_autoInc <= rx_byte[3];
                        r_addr    <= rx_byte[ADDR_W-1:0];
                        r_state   <= S_DATA;
                     end
                     2'b01: begin
                        r_commitPulse <= 1'b1;
                        for (int b = 0; b < 4; b++) begin
                           for (int k = 0; k < N_TAPS; k++) begin
                              r_active[b][k] <= r_shadow[b][k];
                           end
                        end
                     end
                     2'b10: begin
                        for (int b = 0; b < 4; b++) begin
                           for (int k = 0; k < N_TAPS; k++) begin
                              r_shadow[b][k] <= '0;
                           end
                        end
                     end
                     default: r_err <= 1'b1;
                  endcase
               end
               S_DATA: begin
                  if (w_dataOk) begin
                     r_shadow[r_bank][r_addr] <= rx_byte[COEF_W-1:0];
                     if (r_frameBytes != 8'hFF) begin
                        r_frameBytes <= r_frameBytes + 8'd1;
                     end
                  end else begin
                     r_err <= 1'b1;
                  end
                  // The address advances even on a rejected byte so later taps stay aligned.
                  if (r_autoInc) begin
                     r_addr <= r_addr + ADDR_W'(1);
                  end
               end
               default: ;
            endcase
         end
      end
   end

   always_comb begin
      coef_cos_1 = '0;
      coef_sin_1 = '0;
      coef_cos_2 = '0;
      coef_sin_2 = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         coef_cos_1[k*COEF_W +: COEF_W] = r_active[0][k];
         coef_sin_1[k*COEF_W +: COEF_W] = r_active[1][k];
         coef_cos_2[k*COEF_W +: COEF_W] = r_active[2][k];
         coef_sin_2[k*COEF_W +: COEF_W] = r_active[3][k];
      end
   end

   assign commit_pulse = r_commitPulse;
   assign err          = r_err;
   assign frame_bytes  = r_frameBytes;

endmodule

// File: tb/tb_spi_coef_loader.sv
// Self-checking bench for spi_coef_loader: a behavioural model tracks shadow/active banks
// and is compared against the DUT every cycle, plus hand-computed literal expectations.
module tb_spi_coef_loader;

   localparam int COEF_W = 5;
   localparam int N_TAPS = 8;
   localparam int ADDR_W = 3;
   localparam int BANK_W = N_TAPS * COEF_W;

   logic              SCLK = 1'b0;
   logic              reset = 1'b1;
   logic              frame_start = 1'b0;
   logic              rx_valid = 1'b0;
   logic [7:0]        rx_byte = 8'd0;
   logic [BANK_W-1:0] coef_cos_1;
   logic [BANK_W-1:0] coef_sin_1;
   logic [BANK_W-1:0] coef_cos_2;
   logic [BANK_W-1:0] coef_sin_2;
   logic              commit_pulse;
   logic              err;
   logic [7:0]        frame_bytes;

   int nChecks = 0;
   int nErrors = 0;
   bit checking = 1'b0;

   typedef enum {M_IDLE, M_CMD, M_DATA, M_DRAIN} phase_t;
   phase_t mPhase = M_IDLE;
   int mShadow [4][N_TAPS];
   int mActive [4][N_TAPS];
   int mBank = 0;
   int mAddr = 0;
   bit mAuto = 1'b0;
   bit mErr = 1'b0;
   bit mCommit = 1'b0;
   int mBytes = 0;

   spi_coef_loader #(.COEF_W(COEF_W), .N_TAPS(N_TAPS), .ADDR_W(ADDR_W)) dut (
      .SCLK(SCLK),
      .reset(reset),
      .frame_start(frame_start),
      .rx_valid(rx_valid),
      .rx_byte(rx_byte),
      .coef_cos_1(coef_cos_1),
      .coef_sin_1(coef_sin_1),
      .coef_cos_2(coef_cos_2),
      .coef_sin_2(coef_sin_2),
      .commit_pulse(commit_pulse),
      .err(err),
      .frame_bytes(frame_bytes)
   );

   always #5 SCLK = ~SCLK;

   function automatic logic [BANK_W-1:0] packBank(input int bank);
      logic [BANK_W-1:0] p;
      p = '0;
      for (int k = 0; k < N_TAPS; k++) begin
         p[k*COEF_W +: COEF_W] = COEF_W'(mActive[bank][k]);
      end
      return p;
   endfunction

   task automatic checkValue(input string name, input logic [63:0] actual, input logic [63:0] expected);
      nChecks++;
      if (actual !== expected) begin
         nErrors++;
         $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, actual, expected);
      end
   endtask

   // Advance the model by one clock edge using the inputs the DUT just sampled.
   task automatic modelStep(input logic rstIn, input logic fsIn, input logic rvIn, input logic [7:0] b);
      int op;
      mCommit = 1'b0;
      if (rstIn) begin
         for (int i = 0; i < 4; i++) begin
            for (int k = 0; k < N_TAPS; k++) begin
               mShadow[i][k] = 0;
               mActive[i][k] = 0;
            end
         end
         mPhase = M_IDLE;
         mErr   = 1'b0;
         mBytes = 0;
         mBank  = 0;
         mAddr  = 0;
         mAuto  = 1'b0;
      end else if (fsIn) begin
         mPhase = M_CMD;
         mBytes = 0;
      end else if (rvIn) begin
         if (mPhase == M_CMD) begin
            op = int'(b) / 64;
            mPhase = M_DRAIN;
            if (op == 0) begin
               mBank  = (int'(b) / 16) % 4;
               mAuto  = b[3];
               mAddr  = int'(b) % N_TAPS;
               mPhase = M_DATA;
            end else if (op == 1) begin
               mActive = mShadow;
               mCommit = 1'b1;
            end else if (op == 2) begin
               for (int i = 0; i < 4; i++) begin
                  for (int k = 0; k < N_TAPS; k++) mShadow[i][k] = 0;
               end
            end else begin
               mErr = 1'b1;
            end
         end else if (mPhase == M_DATA) begin
            if (int'(b) < (1 << COEF_W)) begin
               mShadow[mBank][mAddr] = int'(b);
               if (mBytes < 255) mBytes++;
            end else begin
               mErr = 1'b1;
            end
            if (mAuto) mAddr = (mAddr + 1) % N_TAPS;
         end
      end
   endtask

   task automatic checkOutput();
      checkValue("cos_1", 64'(coef_cos_1), 64'(packBank(0)));
      checkValue("sin_1", 64'(coef_sin_1), 64'(packBank(1)));
      checkValue("cos_2", 64'(coef_cos_2), 64'(packBank(2)));
      checkValue("sin_2", 64'(coef_sin_2), 64'(packBank(3)));
      checkValue("commit_pulse", 64'(commit_pulse), 64'(mCommit));
      checkValue("err", 64'(err), 64'(mErr));
      checkValue("frame_bytes", 64'(frame_bytes), 64'(mBytes));
   endtask

   always @(negedge SCLK) begin
      if (checking) checkOutput();
   end

   task automatic applyStimulus(input logic rstIn, input logic fsIn, input logic rvIn, input logic [7:0] byteIn);
      @(posedge SCLK);
      modelStep(reset, frame_start, rx_valid, rx_byte);
      #1;
      reset       = rstIn;
      frame_start = fsIn;
      rx_valid    = rvIn;
      rx_byte     = byteIn;
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 8'h00);
   endtask

   task automatic startFrame();
      applyStimulus(1'b0, 1'b1, 1'b0, 8'h00);
   endtask

   task automatic sendByte(input logic [7:0] b);
      applyStimulus(1'b0, 1'b0, 1'b1, b);
   endtask

   task automatic commitFrame();
      startFrame();
      sendByte(8'h40);
      idle(1);
   endtask

   initial begin
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      checking = 1'b1;
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      idle(3);
      checkValue("reset cos_1", 64'(coef_cos_1), 64'h0);
      checkValue("reset sin_2", 64'(coef_sin_2), 64'h0);
      checkValue("reset err", 64'(err), 64'h0);
      checkValue("reset frame_bytes", 64'(frame_bytes), 64'h0);

      // Bank 0 auto-increment burst of 1..8, then commit in a second frame.
      startFrame();
      sendByte(8'h08);
      for (int i = 1; i <= 8; i++) sendByte(8'(i));
      idle(1);
      checkValue("burst frame_bytes", 64'(frame_bytes), 64'd8);
      checkValue("no commit yet", 64'(coef_cos_1), 64'h0);
      commitFrame();
      checkValue("commit pulse high", 64'(commit_pulse), 64'h1);
      checkValue("cos_1 ramp", 64'(coef_cos_1), 64'h41CC520C41);
      checkValue("sin_1 untouched", 64'(coef_sin_1), 64'h0);
      idle(1);
      checkValue("commit pulse low", 64'(commit_pulse), 64'h0);

      // Bank 2 burst starting at tap 6 wraps around to taps 0 and 1.
      startFrame();
      sendByte(8'h2E);
      sendByte(8'h11);
      sendByte(8'h12);
      sendByte(8'h13);
      sendByte(8'h14);
      commitFrame();
      checkValue("cos_2 tap6", 64'(coef_cos_2[30 +: 5]), 64'h11);
      checkValue("cos_2 tap7", 64'(coef_cos_2[35 +: 5]), 64'h12);
      checkValue("cos_2 tap0", 64'(coef_cos_2[0 +: 5]), 64'h13);
      checkValue("cos_2 tap1", 64'(coef_cos_2[5 +: 5]), 64'h14);
      checkValue("cos_1 kept", 64'(coef_cos_1), 64'h41CC520C41);

      // Bank 1 tap 3 without auto-increment: the second byte overwrites the first.
      startFrame();
      sendByte(8'h13);
      sendByte(8'h05);
      sendByte(8'h1F);
      idle(1);
      checkValue("fixed frame_bytes", 64'(frame_bytes), 64'd2);
      commitFrame();
      checkValue("sin_1 tap3", 64'(coef_sin_1), 64'hF8000);

      // Full bank 3 write with no commit, then CLEAR and COMMIT.
      startFrame();
      sendByte(8'h38);
      for (int i = 0; i < 8; i++) sendByte(8'(31 - i));
      idle(2);
      checkValue("sin_2 uncommitted", 64'(coef_sin_2), 64'h0);
      startFrame();
      sendByte(8'h80);
      commitFrame();
      checkValue("cleared cos_1", 64'(coef_cos_1), 64'h0);
      checkValue("cleared cos_2", 64'(coef_cos_2), 64'h0);
      checkValue("cleared sin_1", 64'(coef_sin_1), 64'h0);

      // Oversized data byte: flagged, tap skipped, address still advances.
      startFrame();
      sendByte(8'h08);
      sendByte(8'h25);
      sendByte(8'h03);
      idle(1);
      checkValue("bad byte err", 64'(err), 64'h1);
      checkValue("bad byte not counted", 64'(frame_bytes), 64'd1);
      commitFrame();
      checkValue("bad byte skipped", 64'(coef_cos_1), 64'h60);
      checkValue("err sticky", 64'(err), 64'h1);

      // Reserved command after a fresh reset; following bytes are ignored.
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      idle(1);
      checkValue("err cleared", 64'(err), 64'h0);
      startFrame();
      sendByte(8'hC0);
      sendByte(8'h08);
      sendByte(8'h01);
      idle(1);
      checkValue("reserved err", 64'(err), 64'h1);
      checkValue("reserved drain", 64'(frame_bytes), 64'd0);
      commitFrame();
      checkValue("reserved no write", 64'(coef_cos_1), 64'h0);

      // frame_start on the same edge as a byte: the byte is dropped.
      startFrame();
      applyStimulus(1'b0, 1'b1, 1'b1, 8'h40);
      sendByte(8'h08);
      sendByte(8'h07);
      idle(1);
      checkValue("coincident dropped", 64'(commit_pulse), 64'h0);
      checkValue("coincident count", 64'(frame_bytes), 64'd1);
      commitFrame();
      checkValue("coincident write", 64'(coef_cos_1), 64'h7);

      // Byte counter saturates at 255.
      startFrame();
      sendByte(8'h08);
      for (int i = 0; i < 260; i++) sendByte(8'(i % 32));
      idle(1);
      checkValue("frame_bytes saturate", 64'(frame_bytes), 64'd255);

      // Reset in the middle of a burst wipes everything and commits nothing partial.
      startFrame();
      sendByte(8'h08);
      sendByte(8'h01);
      sendByte(8'h02);
      applyStimulus(1'b1, 1'b0, 1'b0, 8'h00);
      idle(1);
      checkValue("midreset cos_1", 64'(coef_cos_1), 64'h0);
      checkValue("midreset frame_bytes", 64'(frame_bytes), 64'd0);
      commitFrame();
      checkValue("midreset commit", 64'(commit_pulse), 64'h1);
      checkValue("midreset shadow", 64'(coef_cos_1), 64'h0);

      $display("CHECKS %0d ERRORS %0d", nChecks, nErrors);
      $finish;
   end

endmodule
